md_sched: RTL and testbench
===========================

# md_sched

Multi-cycle multiply/divide scheduler for the E stage of the five-stage MIPS pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E-stage operand path (forwarded RD1/RD2), runs a fixed-latency busy sequence, and owns the HI/LO registers. While an operation is in flight, it raises a stall toward the hazard unit so that any D-stage instruction touching HI/LO is held.

## Interface

Parameters:

- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1–31)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1–31)

Ports:

- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- E_Start  input  1  valid HI/LO-class instruction in E this cycle
- E_MDOp  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved
- E_A  input  32  forwarded RD1 (rs)
- E_B  input  32  forwarded RD2 (rt)
- D_UsesMD  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- Busy  output  1  operation in flight
- Stall  output  1  hold F/D and bubble E
- HI  output  32  HI register
- LO  output  32  LO register

## Operation

- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, 5-bit down-counter cnt.
- IDLE with E_Start=1 on a clock edge:
  - MULT/MULTU/DIV/DIVU: latch E_A, E_B and op; cnt ← MULT_CYCLES or DIV_CYCLES; go to RUN.
  - MTHI: HI ← E_A at that edge; stay IDLE.
  - MTLO: LO ← E_A at that edge; stay IDLE.
  - Reserved op: ignored, no state change.
- RUN, each edge:
  - cnt ← cnt−1.
  - When cnt==1 at the edge: write HI/LO from the latched operands and go to IDLE.
- E_Start=1 while in RUN: ignored. This is a protocol violation that Stall prevents; no effect on HI/LO or cnt.
- Results (computed from the latched operands only, never from live E_A/E_B):
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - Divisor 0 (DIV or DIVU): LO = 0xFFFFFFFF, HI = dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Stall = D_UsesMD & (Busy | (E_Start & E_MDOp ≤ 3)). Purely combinational.
- Reset (reset_n=0, asynchronous):
  - HI=0, LO=0, Busy=0, state IDLE, cnt=0, operand latches 0.
  - Stall follows its equation, with Busy=0.
  - Reset mid-RUN abandons the operation; HI/LO return to 0.

## Timing

- E_Start sampled at edge 0 for an N-cycle op:
  - Busy=1 after edge 0, through edge N.
  - HI/LO hold their new values and Busy=0 after edge N.
- An mfhi/mflo sitting in D is stalled through cycle N. It reads the new HI/LO in the cycle after edge N.
- Back-to-back: a second mult/div may be sampled at edge N+1 at the earliest.
- MTHI/MTLO take effect at the sampling edge; a following mfhi/mflo sees the value with no stall.
- No combinational path from E_A/E_B to any output.
- Busy, HI and LO are registered.
- Stall depends combinationally on D_UsesMD, E_Start and E_MDOp.

## Test plan

- Reset: hold reset_n=0 asynchronously mid-cycle -> HI=0, LO=0, Busy=0 immediately. With D_UsesMD=1 and E_Start=0, Stall=0.
- MULT: E_A=0xFFFFFFFD, E_B=7 -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - Same operands with MULTU -> HI=0x00000006, LO=0xFFFFFFEB.
- DIVU 100/7 -> Busy 10 cycles, LO=14, HI=2.
  - DIV 0xFFFFFFF9/2 (−7/2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
  - DIVU 5/0 -> LO=0xFFFFFFFF, HI=5.
- Stall: start DIV; hold D_UsesMD=1 -> Stall=1 in the start cycle and all 10 busy cycles, 0 after.
  - Drive E_Start with MULT mid-RUN with changed E_A -> ignored; final result uses the original operands.
- MTLO E_A=0x12345678 in IDLE -> LO updated at the next edge, Busy stays 0, HI unchanged.
- Reset mid-op: assert reset_n=0 at busy cycle 3 of MULT -> Busy=0, HI=LO=0.
  - After release, a fresh MULTU 3×4 -> LO=12, HI=0 after 5 cycles.

Source files
------------

// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: fixed-latency busy sequence, owns HI/LO.
// Busy and HI/LO are registered; Stall is the only combinational output.
module md_sched #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        E_Start,
   input  logic [2:0]  E_MDOp,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   input  logic        D_UsesMD,
   output logic        Busy,
   output logic        Stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t      state_q;
   logic [4:0]  cnt_q;
   logic [1:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [31:0] hi_q, lo_q;
   logic        busy_q;

   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag, uq_mag, ur_mag;
   logic [31:0] res_hi, res_lo;

   // Signed division runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   always_comb begin
      prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      prod_u = {32'd0, a_q} * {32'd0, b_q};
      a_mag  = a_q[31] ? (~a_q + 32'd1) : a_q;
      b_mag  = b_q[31] ? (~b_q + 32'd1) : b_q;
      uq_mag = 32'd0;
      ur_mag = 32'd0;
      if (b_q != 32'd0) begin
         uq_mag = a_mag / b_mag;
         ur_mag = a_mag % b_mag;
      end
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (op_q)
         2'd0: {res_hi, res_lo} = prod_s;
         2'd1: {res_hi, res_lo} = prod_u;
         2'd2: begin
            if (b_q == 32'd0) begin
               res_hi = a_q;
               res_lo = 32'hFFFF_FFFF;
            end else begin
               res_lo = (a_q[31] ^ b_q[31]) ? (~uq_mag + 32'd1) : uq_mag;
               res_hi = a_q[31] ? (~ur_mag + 32'd1) : ur_mag;
            end
         end
         default: begin
            if (b_q == 32'd0) begin
               res_hi = a_q;
               res_lo = 32'hFFFF_FFFF;
            end else begin
               res_lo = a_q / b_q;
               res_hi = a_q % b_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         op_q    <= 2'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (E_Start) begin
                  case (E_MDOp)
                     3'd0, 3'd1, 3'd2, 3'd3: begin
                        a_q     <= E_A;
                        b_q     <= E_B;
                        op_q    <= E_MDOp[1:0];
                        cnt_q   <= E_MDOp[1] ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                     end
                     3'd4:    hi_q <= E_A;
                     3'd5:    lo_q <= E_A;
                     default: ;
                  endcase
               end
            end
            default: begin
               // Starts arriving while running are dropped; Stall keeps them from occurring.
               cnt_q <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  hi_q    <= res_hi;
                  lo_q    <= res_lo;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign Busy  = busy_q;
   assign HI    = hi_q;
   assign LO    = lo_q;
   assign Stall = D_UsesMD & (busy_q | (E_Start & (E_MDOp <= 3'd3)));

endmodule

// File: tb/tb_md_sched.sv
// Randomized bench for md_sched: driver pushes reference HI/LO per accepted op,
// monitor tracks expected busy window and pops/compares when results appear.
module tb_md_sched;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        E_Start;
   logic [2:0]  E_MDOp;
   logic [31:0] E_A, E_B;
   logic        D_UsesMD;
   logic        Busy, Stall;
   logic [31:0] HI, LO;

   md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset_n(reset_n), .E_Start(E_Start), .E_MDOp(E_MDOp),
      .E_A(E_A), .E_B(E_B), .D_UsesMD(D_UsesMD), .Busy(Busy), .Stall(Stall),
      .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic [31:0] hi; logic [31:0] lo; } exp_t;
   exp_t        q[$];
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   int          vecs = 0, errs = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: plain 64-bit arithmetic on the architectural definitions.
   function automatic exp_t ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] hi, input logic [31:0] lo);
      exp_t e;
      longint x, y, p;
      longint unsigned pu;
      e.hi = hi;
      e.lo = lo;
      x = $signed(a);
      y = $signed(b);
      case (op)
         3'd0: begin p = x * y; e = p; end
         3'd1: begin pu = {32'd0, a} * {32'd0, b}; e = pu; end
         3'd2: if (b == 0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
               else begin p = x / y; e.lo = p[31:0]; p = x % y; e.hi = p[31:0]; end
         3'd3: if (b == 0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
               else begin e.lo = a / b; e.hi = a % b; end
         3'd4: e.hi = a;
         3'd5: e.lo = a;
         default: ;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0000_0001;
         4: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic step(input logic st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic du);
      @(posedge clk);
      #1;
      E_Start = st; E_MDOp = op; E_A = a; E_B = b; D_UsesMD = du;
   endtask

   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic du);
      exp_t e;
      step(1'b1, op, a, b, du);
      if (op <= 3'd5) begin
         e = ref_op(op, a, b, m_hi, m_lo);
         m_hi = e.hi;
         m_lo = e.lo;
         q.push_back(e);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic du, input int inj_k, input bit rnd);
      int n;
      start_op(op, a, b, du);
      if (op <= 3'd3) begin
         n = (op <= 3'd1) ? MC : DC;
         for (int k = 1; k <= n; k++) begin
            if (rnd)
               step($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), pick(), pick(),
                    1'($urandom_range(0, 1)));
            else
               step(k == inj_k, 3'd0, 32'hDEAD_BEEF, 32'h0000_0011, du);
         end
      end
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_rst Busy", 64'(Busy), 64'd0);
      chk("async_rst HI", 64'(HI), 64'd0);
      chk("async_rst LO", 64'(LO), 64'd0);
      q.delete();
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(posedge clk);
      #3;
      reset_n = 1'b1;
   endtask

   // Monitor: expected busy window derived from accepted starts, not from the DUT.
   int         rem = 0;
   logic       cap_st = 1'b0;
   logic [2:0] cap_op = 3'd0;

   task automatic pop_chk(input string nm);
      exp_t e;
      if (q.size() == 0) begin
         vecs++;
         errs++;
         $display("FAIL %s: result appeared with no expected entry, HI=%h LO=%h", nm, HI, LO);
      end else begin
         e = q.pop_front();
         chk({nm, " HI"}, 64'(HI), 64'(e.hi));
         chk({nm, " LO"}, 64'(LO), 64'(e.lo));
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         rem = 0;
         cap_st = 1'b0;
         chk("rst Busy", 64'(Busy), 64'd0);
         chk("rst HI", 64'(HI), 64'd0);
         chk("rst LO", 64'(LO), 64'd0);
         chk("rst Stall", 64'(Stall), 64'(D_UsesMD & E_Start & (E_MDOp <= 3'd3)));
      end else begin
         if (rem > 0) begin
            rem--;
            if (rem == 0) pop_chk("muldiv");
         end else if (cap_st && cap_op <= 3'd3) begin
            rem = (cap_op <= 3'd1) ? MC : DC;
         end else if (cap_st && (cap_op == 3'd4 || cap_op == 3'd5)) begin
            pop_chk("mthilo");
         end
         chk("Busy", 64'(Busy), 64'(rem > 0));
         chk("Stall", 64'(Stall), 64'(D_UsesMD & ((rem > 0) | (E_Start & (E_MDOp <= 3'd3)))));
         cap_st = E_Start;
         cap_op = E_MDOp;
      end
   end

   initial begin
      reset_n = 1'b0;
      E_Start = 1'b0; E_MDOp = 3'd0; E_A = 32'd0; E_B = 32'd0; D_UsesMD = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("init Stall", 64'(Stall), 64'd0);
      chk("init HI", 64'(HI), 64'd0);
      #2;
      reset_n = 1'b1;

      issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, 1'b0);
      issue(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, 1'b0);
      issue(3'd3, 32'd100, 32'd7, 1'b0, 0, 1'b0);
      issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 1'b0);
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
      issue(3'd3, 32'd5, 32'd0, 1'b0, 0, 1'b0);
      issue(3'd2, 32'd1000, 32'd3, 1'b1, 4, 1'b0);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      issue(3'd4, 32'hCAFE_F00D, 32'd0, 1'b1, 0, 1'b0);
      issue(3'd5, 32'h1234_5678, 32'd0, 1'b1, 0, 1'b0);
      issue(3'd6, 32'h5555_5555, 32'd0, 1'b1, 0, 1'b0);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

      start_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
      mid_reset();
      issue(3'd1, 32'd3, 32'd4, 1'b0, 0, 1'b0);
      step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)), 0, 1'b1);
         if ($urandom_range(0, 3) == 0) step(1'b0, 3'd0, 32'd0, 32'd0, 1'($urandom_range(0, 1)));
      end

      repeat (DC + 4) step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
      vecs++;
      if (q.size() != 0) begin
         errs++;
         $display("FAIL drain: %0d expected results never appeared, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
